// File: rtl/game_state_ctrl_if.sv
// Handshake and status bundle between the penalty-game controller and its host.
// The master drives the user/link/kick inputs; the slave (the controller) drives state and scores.
interface game_state_ctrl_if #(
  parameter int CNT_W   = 5,
  parameter int SCORE_W = 4
);
  logic               left_clicked;
  logic               solo_enable;
  logic               connect_ok;
  logic               host_first;
  logic               kick_done;
  logic               goal;
  logic [2:0]         game_state;
  logic               game_mode;
  logic [CNT_W-1:0]   kick_cnt;
  logic [SCORE_W-1:0] score_own;
  logic [SCORE_W-1:0] score_opp;
  logic               draw;

  modport master (
    output left_clicked, solo_enable, connect_ok, host_first, kick_done, goal,
    input  game_state, game_mode, kick_cnt, score_own, score_opp, draw
  );

  modport slave (
    input  left_clicked, solo_enable, connect_ok, host_first, kick_done, goal,
    output game_state, game_mode, kick_cnt, score_own, score_opp, draw
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Penalty-shootout game controller: SOLO keeper mode against a fixed target, or MULTI
// alternating kicks against a peer with sudden death, draw detection and idle return.
module game_state_ctrl #(
  parameter int ROUNDS       = 5,
  parameter int WIN_SCORE    = 3,
  parameter int MAX_SD       = 5,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int CNT_W        = 5,
  parameter int SCORE_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  game_state_ctrl_if.slave bus
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]   SOLO_LAST = CNT_W'(ROUNDS);
  localparam logic [CNT_W-1:0]   REG_LAST  = CNT_W'(2 * ROUNDS);
  localparam logic [CNT_W-1:0]   SD_LAST   = CNT_W'(2 * (ROUNDS + MAX_SD));
  localparam logic [SCORE_W-1:0] WIN_MIN   = SCORE_W'(WIN_SCORE);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_KEEPER  = 3'd1,
    ST_SHOOTER = 3'd2,
    ST_WINNER  = 3'd3,
    ST_LOSER   = 3'd4
  } state_e;

  typedef enum logic {
    MODE_MULTI = 1'b0,
    MODE_SOLO  = 1'b1
  } mode_e;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nx;
  logic [SCORE_W-1:0] own_q, own_d, own_nx;
  logic [SCORE_W-1:0] opp_q, opp_d, opp_nx;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               draw_q, draw_d;
  logic               link_lost;

  // Counts as they would stand after the kick resolving this cycle; SOLO scores saves.
  assign cnt_nx = cnt_q + CNT_W'(1);
  assign own_nx = own_q + SCORE_W'((mode_q == MODE_SOLO) ? !bus.goal
                                                         : (state_q == ST_SHOOTER && bus.goal));
  assign opp_nx = opp_q + SCORE_W'(mode_q == MODE_MULTI && state_q == ST_KEEPER && bus.goal);

  assign link_lost = (mode_q == MODE_MULTI) && !bus.connect_ok && (state_q != ST_START);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    opp_d   = opp_q;
    idle_d  = '0;
    draw_d  = 1'b0;

    if (state_q == ST_START) mode_d = mode_e'(bus.solo_enable);

    if (link_lost) begin
      state_d = ST_START;
      cnt_d   = '0;
      own_d   = '0;
      opp_d   = '0;
    end else begin
      case (state_q)
        ST_START: begin
          if (bus.left_clicked && (bus.solo_enable || bus.connect_ok)) begin
            state_d = (!bus.solo_enable && bus.host_first) ? ST_SHOOTER : ST_KEEPER;
            cnt_d   = '0;
            own_d   = '0;
            opp_d   = '0;
          end
        end

        ST_KEEPER, ST_SHOOTER: begin
          if (bus.kick_done) begin
            cnt_d = cnt_nx;
            own_d = own_nx;
            opp_d = opp_nx;
            if (mode_q == MODE_SOLO) begin
              if (cnt_nx == SOLO_LAST) state_d = (own_nx >= WIN_MIN) ? ST_WINNER : ST_LOSER;
            end else if (!cnt_nx[0] && cnt_nx >= REG_LAST && own_nx != opp_nx) begin
              state_d = (own_nx > opp_nx) ? ST_WINNER : ST_LOSER;
            end else if (cnt_nx == SD_LAST) begin
              state_d = ST_START;
              draw_d  = 1'b1;
            end else begin
              state_d = (state_q == ST_KEEPER) ? ST_SHOOTER : ST_KEEPER;
            end
          end
        end

        ST_WINNER, ST_LOSER: begin
          if (bus.left_clicked || idle_q == IDLE_LAST) state_d = ST_START;
          else                                         idle_d  = idle_q + IDLE_W'(1);
        end

        default: state_d = ST_START;
      endcase
    end
  end

  // NOTE: reset is synchronous, so it wins only at a clock edge and a kick in that cycle is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_START;
      mode_q  <= MODE_MULTI;
      cnt_q   <= '0;
      own_q   <= '0;
      opp_q   <= '0;
      idle_q  <= '0;
      draw_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register reading pre-edge values.
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      opp_q   <= opp_d;
      idle_q  <= idle_d;
      draw_q  <= draw_d;
    end
  end

  assign bus.game_state = state_q;
  assign bus.game_mode  = mode_q;
  assign bus.kick_cnt   = cnt_q;
  assign bus.score_own  = own_q;
  assign bus.score_opp  = opp_q;
  assign bus.draw       = draw_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Vector-table bench for game_state_ctrl: expected outputs are queued as each
// stimulus row is driven and compared one clock later.
module tb_game_state_ctrl;

  localparam int IDLE_TIMEOUT = 1000;
  localparam int CNT_W        = 5;
  localparam int SCORE_W      = 4;

  localparam logic [2:0] S_START   = 3'd0;
  localparam logic [2:0] S_KEEPER  = 3'd1;
  localparam logic [2:0] S_SHOOTER = 3'd2;
  localparam logic [2:0] S_WINNER  = 3'd3;
  localparam logic [2:0] S_LOSER   = 3'd4;

  typedef struct {
    logic        rst, click, solo, conn, host, kd, goal;
    logic [17:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  vec_t        vecs[$];
  logic [17:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  game_state_ctrl_if #(.CNT_W(CNT_W), .SCORE_W(SCORE_W)) bus ();

  game_state_ctrl #(
    .ROUNDS(5), .WIN_SCORE(3), .MAX_SD(5), .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .CNT_W(CNT_W), .SCORE_W(SCORE_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [17:0] pk(input logic [2:0] st, input logic md, input int cnt,
                                     input int own, input int opp, input logic dr);
    logic [4:0] c;
    logic [3:0] o, p;
    c = cnt[4:0];
    o = own[3:0];
    p = opp[3:0];
    return {st, md, c, o, p, dr};
  endfunction

  task automatic add(input logic r, c, s, n, h, k, g, input logic [2:0] st, input logic md,
                     input int cnt, input int own, input int opp, input logic dr);
    vec_t v;
    v.rst = r; v.click = c; v.solo = s; v.conn = n; v.host = h; v.kd = k; v.goal = g;
    v.exp = pk(st, md, cnt, own, opp, dr);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d md=%0d cnt=%0d own=%0d opp=%0d draw=%0d, want st=%0d md=%0d cnt=%0d own=%0d opp=%0d draw=%0d",
               name, act[17:15], act[14], act[13:9], act[8:5], act[4:1], act[0],
               exp[17:15], exp[14], exp[13:9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic apply(input int idx);
    vec_t        v;
    logic [17:0] act;
    v = vecs[idx];
    rst              = v.rst;
    bus.left_clicked = v.click;
    bus.solo_enable  = v.solo;
    bus.connect_ok   = v.conn;
    bus.host_first   = v.host;
    bus.kick_done    = v.kd;
    bus.goal         = v.goal;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    act = {bus.game_state, bus.game_mode, bus.kick_cnt, bus.score_own, bus.score_opp, bus.draw};
    check($sformatf("vec%0d", idx), act, sb.pop_front());
  endtask

  initial begin
    int own, opp;
    logic g;

    // Fields: rst click solo conn host kd goal | state mode cnt own opp draw
    add(1,0,0,1,0,0,0, S_START,  0,0,0,0,0);
    add(1,0,1,1,0,1,1, S_START,  0,0,0,0,0);
    // SOLO win: saves on kicks 1,3,5
    add(0,0,1,1,0,0,0, S_START,  1,0,0,0,0);
    add(0,1,1,1,0,0,0, S_KEEPER, 1,0,0,0,0);
    add(0,0,1,1,0,1,0, S_KEEPER, 1,1,1,0,0);
    add(0,0,1,1,0,1,1, S_KEEPER, 1,2,1,0,0);
    add(0,0,1,1,0,1,0, S_KEEPER, 1,3,2,0,0);
    add(0,0,1,1,0,1,1, S_KEEPER, 1,4,2,0,0);
    add(0,0,1,1,0,1,0, S_WINNER, 1,5,3,0,0);
    add(0,0,0,0,0,1,0, S_WINNER, 1,5,3,0,0);
    add(0,1,1,1,0,0,0, S_START,  1,5,3,0,0);
    // SOLO loss, click during play ignored, then a fresh game clears the counts
    add(0,1,1,1,0,0,0, S_KEEPER, 1,0,0,0,0);
    add(0,0,1,1,0,1,1, S_KEEPER, 1,1,0,0,0);
    add(0,1,1,1,0,1,1, S_KEEPER, 1,2,0,0,0);
    add(0,0,1,1,0,1,0, S_KEEPER, 1,3,1,0,0);
    add(0,0,1,1,0,1,1, S_KEEPER, 1,4,1,0,0);
    add(0,0,1,1,0,1,0, S_LOSER,  1,5,2,0,0);
    add(0,1,1,1,0,0,0, S_START,  1,5,2,0,0);
    add(0,1,1,1,0,0,0, S_KEEPER, 1,0,0,0,0);
    add(0,0,1,1,0,1,1, S_KEEPER, 1,1,0,0,0);
    add(1,0,1,1,0,1,0, S_START,  0,0,0,0,0);
    // MULTI host-first win 4-3; solo_enable flipped mid-game
    add(0,0,0,1,1,0,0, S_START,   0,0,0,0,0);
    add(0,1,0,1,1,0,0, S_SHOOTER, 0,0,0,0,0);
    add(0,0,0,1,1,1,1, S_KEEPER,  0,1,1,0,0);
    add(0,0,0,1,1,1,1, S_SHOOTER, 0,2,1,1,0);
    add(0,0,1,1,1,0,0, S_SHOOTER, 0,2,1,1,0);
    add(0,0,0,1,1,1,1, S_KEEPER,  0,3,2,1,0);
    add(0,0,0,1,1,1,0, S_SHOOTER, 0,4,2,1,0);
    add(0,0,0,1,1,1,1, S_KEEPER,  0,5,3,1,0);
    add(0,0,0,1,1,1,1, S_SHOOTER, 0,6,3,2,0);
    add(0,0,0,1,1,1,1, S_KEEPER,  0,7,4,2,0);
    add(0,0,0,1,1,1,0, S_SHOOTER, 0,8,4,2,0);
    add(0,0,0,1,1,1,0, S_KEEPER,  0,9,4,2,0);
    add(0,0,0,1,1,1,1, S_WINNER,  0,10,4,3,0);
    // Idle timeout: WINNER for IDLE_TIMEOUT cycles, ignoring a kick, then START
    add(0,0,0,1,1,1,1, S_WINNER,  0,10,4,3,0);
    for (int i = 2; i < IDLE_TIMEOUT; i++) add(0,0,0,1,1,0,0, S_WINNER, 0,10,4,3,0);
    add(0,0,0,1,1,0,0, S_START,   0,10,4,3,0);
    // MULTI keeper-first, 3-3 after regulation, sudden-death pair decides at 12
    add(0,1,0,1,0,0,0, S_KEEPER,  0,0,0,0,0);
    own = 0;
    opp = 0;
    for (int k = 1; k <= 10; k++) begin
      g = ((k + 1) / 2 <= 3);
      if (k % 2 == 1) opp += int'(g);
      else            own += int'(g);
      add(0,0,0,1,0,1,g, (k % 2 == 1) ? S_SHOOTER : S_KEEPER, 0,k,own,opp,0);
    end
    add(0,0,0,1,0,1,0, S_SHOOTER, 0,11,3,3,0);
    add(0,0,0,1,0,1,1, S_WINNER,  0,12,4,3,0);
    add(0,1,0,1,0,0,0, S_START,   0,12,4,3,0);
    // MULTI 0-0 through all sudden death: draw pulse at kick 20
    add(0,1,0,1,1,0,0, S_SHOOTER, 0,0,0,0,0);
    for (int k = 1; k < 20; k++) add(0,0,0,1,1,1,0, (k % 2 == 1) ? S_KEEPER : S_SHOOTER, 0,k,0,0,0);
    add(0,0,0,1,1,1,0, S_START,   0,20,0,0,1);
    add(0,0,0,1,1,0,0, S_START,   0,20,0,0,0);
    // Link down: no start without link; drop on kick 4 aborts and clears
    add(0,1,0,0,1,0,0, S_START,   0,20,0,0,0);
    add(0,1,0,1,1,0,0, S_SHOOTER, 0,0,0,0,0);
    add(0,0,0,1,1,1,1, S_KEEPER,  0,1,1,0,0);
    add(0,0,0,1,1,1,1, S_SHOOTER, 0,2,1,1,0);
    add(0,0,0,1,1,1,1, S_KEEPER,  0,3,2,1,0);
    add(0,0,0,0,1,1,1, S_START,   0,0,0,0,0);
    add(0,0,0,0,1,0,0, S_START,   0,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) apply(i);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 5, regulation kicks per player.
REQ-002 SHALL have parameter WIN_SCORE, default 3, SOLO saves needed to win.
REQ-003 SHALL have parameter MAX_SD, default 5, maximum MULTI sudden-death kick pairs.
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 1000, cycles before a terminal state auto-returns to START.
REQ-005 SHALL have parameters CNT_W, default 5, and SCORE_W, default 4. CNT_W holds 2*(ROUNDS+MAX_SD). SCORE_W holds ROUNDS+MAX_SD.
REQ-006 SHALL have port clk, input, 1, clock. Reset is rst, synchronous, active-high; clock is clk.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port left_clicked, input, 1, single-cycle user click pulse.
REQ-009 SHALL have port solo_enable, input, 1, requests SOLO mode (0 requests MULTI).
REQ-010 SHALL have port connect_ok, input, 1, peer link healthy.
REQ-011 SHALL have port host_first, input, 1, MULTI: 1 means the local player shoots first.
REQ-012 SHALL have port kick_done, input, 1, single-cycle pulse: current kick resolved.
REQ-013 SHALL have port goal, input, 1, qualified by kick_done: 1 means the ball went in.
REQ-014 SHALL have port game_state, output, 3, encoding START=0, KEEPER=1, SHOOTER=2, WINNER=3, LOSER=4.
REQ-015 SHALL have port game_mode, output, 1, encoding MULTI=0, SOLO=1.
REQ-016 SHALL have port kick_cnt, output, CNT_W, kicks completed this game.
REQ-017 SHALL have port score_own, output, SCORE_W, local player score.
REQ-018 SHALL have port score_opp, output, SCORE_W, opponent score.
REQ-019 SHALL have port draw, output, 1, single-cycle pulse on unresolved MULTI draw.

Function
REQ-020 All outputs SHALL be registered. Each transition SHALL appear on the clock edge after the triggering input cycle.
REQ-021 game_mode SHALL update from solo_enable only while game_state==START, and SHALL hold otherwise.
REQ-022 In START, left_clicked SHALL leave START as follows, and otherwise START SHALL hold:
- SOLO: go to KEEPER.
- MULTI with connect_ok=1: go to SHOOTER if host_first=1, else KEEPER.
- MULTI with connect_ok=0: stay in START.
REQ-023 Entering KEEPER or SHOOTER from START SHALL clear kick_cnt, score_own and score_opp.
REQ-024 In KEEPER or SHOOTER, kick_done SHALL increment kick_cnt. left_clicked SHALL be ignored there.
REQ-025 SOLO scoring: kick_done with goal=0 SHALL increment score_own. score_opp SHALL stay 0.
REQ-026 SOLO decision: on the kick_done that makes kick_cnt==ROUNDS, go to WINNER if the updated score_own>=WIN_SCORE, else LOSER. Before that kick, stay in KEEPER.
REQ-027 MULTI scoring, applied on each kick_done:
- In SHOOTER with goal=1: increment score_own.
- In KEEPER with goal=1: increment score_opp.
REQ-028 MULTI alternation: each kick_done that does not end the game SHALL toggle KEEPER<->SHOOTER.
REQ-029 MULTI decision SHALL use the updated counts, and SHALL be evaluated only when the updated kick_cnt is even and >=2*ROUNDS:
- score_own>score_opp: go to WINNER.
- score_own<score_opp: go to LOSER.
- Equal: continue in sudden death.
REQ-030 If scores are equal when the updated kick_cnt==2*(ROUNDS+MAX_SD), the block SHALL go to START and pulse draw for one cycle.
REQ-031 In MULTI, if connect_ok==0 in any state except START, the next state SHALL be START and counters SHALL clear. This SHALL take priority over a simultaneous kick_done.
REQ-032 In WINNER or LOSER, left_clicked SHALL return to START. kick_done SHALL be ignored there.
REQ-033 A terminal-state idle counter SHALL:
- clear on entering WINNER or LOSER;
- force START after IDLE_TIMEOUT consecutive cycles without left_clicked.
REQ-034 kick_cnt and the scores SHALL hold their values in WINNER and LOSER, and SHALL clear only on leaving START for play.
REQ-035 The 3-bit illegal game_state codes 5-7 SHALL recover to START on the next cycle.

Reset
REQ-036 rst SHALL force, on the next edge, regardless of the current state:
- game_state=START;
- game_mode=MULTI;
- kick_cnt=0, score_own=0, score_opp=0;
- draw=0;
- idle counter=0.
REQ-037 rst asserted during a kick_done cycle SHALL discard that kick.

Verification
REQ-038 SOLO, 5 kicks with goal pattern 0,1,0,1,0 -> KEEPER throughout, score_own=3, WINNER after the 5th kick_done.
REQ-039 SOLO, goal pattern 1,1,0,1,0 -> score_own=2, LOSER after the 5th kick; left_clicked -> START, and the next game clears the counters.
REQ-040 MULTI, host_first=1, 10 kicks ending with own=4, opp=3 -> states alternate SHOOTER/KEEPER, WINNER after kick 10.
REQ-041 MULTI, tied 3-3 after 10 kicks, then pair (goal=1 shooting, goal=0 keeping) -> WINNER at kick_cnt=12. Tie persisting to kick 20 -> START and a one-cycle draw pulse.
REQ-042 MULTI, connect_ok dropped in the same cycle as kick_done at kick 4 -> START, scores 0, kick not counted. solo_enable toggled mid-game -> game_mode unchanged.
REQ-043 WINNER held with no click for IDLE_TIMEOUT cycles -> START. rst mid-game -> all outputs at reset values on the next edge.
